mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative signed multiply/divide unit that produces the HI and LO registers for the multicycle CPU datapath. Its hi/lo outputs drive the HI and LO inputs of the register-write-data mux, which are currently tied to zero. The control unit launches an operation with a one-cycle start pulse and waits for done. On divide-by-zero it raises div_zero so the control unit can vector to the DIV_ZERO exception address (255).

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; iteration count = WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start_mult  input  1  one-cycle pulse: begin signed a*b
start_div  input  1  one-cycle pulse: begin signed a/b
a  input  WIDTH  operand A (register A output); multiplicand or dividend
b  input  WIDTH  operand B (register B output); multiplier or divisor
hi  output  WIDTH  HI register: product[2W-1:W] or remainder
lo  output  WIDTH  LO register: product[W-1:0] or quotient
busy  output  1  operation in progress
done  output  1  one-cycle pulse; hi/lo hold the new result
div_zero  output  1  one-cycle pulse; divide launched with b == 0

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, MULT, DIV, DONE.
- IDLE, start sampled at edge E0:
  - Operands a and b are latched at E0; later changes to a/b are ignored.
  - start_mult=1: go to MULT; busy=1 from E0.
  - start_div=1 and b!=0: go to DIV; busy=1 from E0.
  - start_div=1 and b==0: stay in IDLE; div_zero=1 for exactly the cycle after E0; hi/lo unchanged; busy stays 0.
  - start_mult and start_div both high: start_mult wins; start_div is ignored.
- Any start pulse seen while busy=1 or in DONE is ignored; no queuing.
- MULT: radix-2 Booth on {A_acc, Q, q-1}.
  - One iteration per edge, edges E1..E32 (WIDTH iterations).
  - Each iteration: add/subtract the multiplicand per {Q[0], q-1}, then arithmetic right shift of the combined register.
- DIV: restoring division on operand magnitudes, one iteration per edge, E1..E32.
  - Signs applied when loading hi/lo at the final edge.
  - Quotient negative iff sign(a) != sign(b); truncation is toward zero.
  - Remainder takes the sign of a.
  - -2^(W-1) / -1 wraps: lo=0x80000000, hi=0. No overflow flag.
- Completion at edge E32 (after the last iteration):
  - hi/lo are loaded.
  - State goes to DONE, busy falls to 0, done=1 for one cycle.
  - At E33 the state returns to IDLE and done falls to 0.
- Latency: result is visible and done=1 during the cycle after E32, i.e. 32 cycles after the start edge. The control unit may issue a new start in the DONE cycle; it is accepted at E33 only if the state is IDLE at that edge. DONE ignores starts, so the earliest accepted start is at E34.
- hi/lo hold their value at all times except the single completion edge. They never show intermediate values.
- Counter increments modulo 2^CNT_W, counts 0..WIDTH-1, and clears on completion.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3) -> done at E0+32 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 32 cycles.
- mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then mult 0xFFFFFFFF*1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 7/0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- div with b=0 after a prior mult result -> div_zero=1 for one cycle after E0, busy never rises, done never pulses, hi/lo keep the previous values.
- start_mult pulsed again at E10 of a running div, and start_mult+start_div together in IDLE -> the second start is ignored (div result correct); the simultaneous start performs a mult.
- reset driven low at E15 of a mult, asynchronously between edges -> hi=lo=0, busy=0 immediately; after release, a fresh mult 3*4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/operand/result bundle between control unit and multiply/divide unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  modport master (output start_mult, start_div, a, b, input hi, lo, busy, done, div_zero);
  modport slave (input start_mult, start_div, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed Booth multiply / restoring divide producing HI and LO
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t           state;
  logic [WIDTH:0]   acc, m, mul_sum, div_sh, div_diff, acc_n;
  logic [WIDTH-1:0] q, q_n, abs_a, abs_b, hi_r, lo_r, res_hi, res_lo, rem;
  logic [CNT_W-1:0] cnt;
  logic             q_1, q1_n, neg_q, neg_r, busy_r, done_r, div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
  // acc is one bit wider so Booth survives a -2^(W-1) multiplicand and the divide shift-in
  always_comb begin
    mul_sum  = (q[0] & ~q_1) ? acc - m : (~q[0] & q_1) ? acc + m : acc;
    div_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_diff = div_sh - m;
    acc_n    = (state == MULT) ? {mul_sum[WIDTH], mul_sum[WIDTH:1]} : div_diff[WIDTH] ? div_sh : div_diff;
    q_n      = (state == MULT) ? {mul_sum[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~div_diff[WIDTH]};
    q1_n     = (state == MULT) ? q[0] : q_1;
    rem      = acc_n[WIDTH-1:0];
    res_hi   = (state == MULT) ? rem : neg_r ? -rem : rem;
    res_lo   = (state == MULT) ? q_n : neg_q ? -q_n : q_n;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      m          <= '0;
      q          <= '0;
      q_1        <= 1'b0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_mult) begin
            state  <= MULT;
            busy_r <= 1'b1;
            acc    <= '0;
            m      <= {bus.a[WIDTH-1], bus.a};
            q      <= bus.b;
            q_1    <= 1'b0;
          end else if (bus.start_div && bus.b != '0) begin
            state  <= DIV;
            busy_r <= 1'b1;
            acc    <= '0;
            m      <= {1'b0, abs_b};
            q      <= abs_a;
            q_1    <= 1'b0;
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r  <= bus.a[WIDTH-1];
          end else if (bus.start_div) begin
            div_zero_r <= 1'b1;
          end
        end
        MULT, DIV: begin
          acc <= acc_n;
          q   <= q_n;
          q_1 <= q1_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi_r   <= res_hi;
            lo_r   <= res_lo;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            cnt    <= '0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with a 64-bit reference model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] last_res = '0;
  logic [63:0] mon_e;
  always #5 clk = ~clk;
  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, qv, rv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!is_div) return sa * sbv;
    qv = sa / sbv;
    rv = sa % sbv;
    return {rv[31:0], qv[31:0]};
  endfunction
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("hi", bus.hi, mon_e[63:32]);
        check("lo", bus.lo, mon_e[31:0]);
        last_res = mon_e;
      end
    end
  end
  task automatic run_op(input logic is_div, input logic both, input logic [31:0] a, input logic [31:0] b, input int poke);
    int cyc = 0;
    int bcnt = 0;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start_mult = !is_div || both;
    bus.start_div = is_div || both;
    sb.push_back(model(is_div && !both, a, b));
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy === 1'b1) bcnt++;
      bus.start_mult = (cyc == poke);
      @(negedge clk);
      cyc++;
    end
    bus.start_mult = 1'b0;
    check("latency", cyc, 32);
    check("busy_cycles", bcnt, 32);
    @(negedge clk);
    check("done_fall", bus.done, 0);
  endtask
  initial begin
    reset = 1'b0;
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_flags", {bus.busy, bus.done, bus.div_zero}, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 0, 32'd7, 32'hFFFFFFFD, -1);
    run_op(0, 0, 32'h80000000, 32'h80000000, -1);
    run_op(0, 0, 32'hFFFFFFFF, 32'd1, -1);
    run_op(1, 0, 32'hFFFFFFF9, 32'd2, -1);
    run_op(1, 0, 32'd7, 32'hFFFFFFFE, -1);
    run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, -1);
    run_op(0, 0, 32'h00012345, 32'hFFFF0001, -1);
    @(negedge clk);
    bus.a = 32'h1234;
    bus.b = '0;
    bus.start_div = 1'b1;
    @(negedge clk);
    bus.start_div = 1'b0;
    check("dz_pulse", bus.div_zero, 1);
    check("dz_busy", bus.busy, 0);
    check("dz_hi", bus.hi, last_res[63:32]);
    check("dz_lo", bus.lo, last_res[31:0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dz_flags", {bus.busy, bus.done, bus.div_zero}, 0);
    end
    check("dz_hi_hold", bus.hi, last_res[63:32]);
    run_op(1, 0, 32'd1000, 32'd7, 9);
    run_op(0, 1, 32'hFFFFFFF0, 32'd5, -1);
    for (int i = 0; i < 6; i++) begin
      run_op(i[0], 0, $urandom, $urandom | 32'd1, -1);
    end
    @(negedge clk);
    bus.a = 32'd5;
    bus.b = 32'd6;
    bus.start_mult = 1'b1;
    @(posedge clk);
    #1 bus.start_mult = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    check("arst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 0, 32'd3, 32'd4, -1);
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
